// File: rtl/cisc_pkg.sv
// Shared definitions for the microprogrammed CISC control path: microword
// field positions and the sequencing/condition encodings.
package cisc_pkg;

    localparam int CWR_W    = 34;
    localparam int INS_W    = 16;

    localparam int SEQ_MSB  = 33;
    localparam int SEQ_LSB  = 32;
    localparam int LDIR_BIT = 8;
    localparam int COND_MSB = 7;
    localparam int COND_LSB = 6;

    // Opcode nibble of the instruction word, used for dispatch.
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;

    typedef enum logic [1:0] {
        SEQ_INC  = 2'b00,
        SEQ_JMP  = 2'b01,
        SEQ_DISP = 2'b10,
        SEQ_BR   = 2'b11
    } seq_op_e;

    typedef enum logic [1:0] {
        C_ALW = 2'b00,
        C_Z   = 2'b01,
        C_C   = 2'b10,
        C_NZ  = 2'b11
    } cond_e;

endpackage

// File: rtl/upc_next_logic.sv
// Next micro-address selection: condition mux followed by the
// increment / jump / dispatch / branch address mux. Purely combinational.
module upc_next_logic
    import cisc_pkg::*;
#(
    parameter int                 UADDR_W   = 6,
    parameter logic [UADDR_W-5:0] DISP_BASE = 2'b01
) (
    input  logic [UADDR_W-1:0] upc,
    input  seq_op_e            seq_op,
    input  cond_e              cond,
    input  logic [UADDR_W-1:0] addr,
    input  logic [3:0]         opcode,
    input  logic               z_flag,
    input  logic               c_flag,
    output logic [UADDR_W-1:0] uaddr
);

    logic               cond_true;
    logic [UADDR_W-1:0] upc_inc;

    // Natural wrap at the top of the control store.
    assign upc_inc = upc + UADDR_W'(1);

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            C_ALW:   cond_true = 1'b1;
            C_Z:     cond_true = z_flag;
            C_C:     cond_true = c_flag;
            C_NZ:    cond_true = ~z_flag;
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        uaddr = upc_inc;
        case (seq_op)
            SEQ_INC:  uaddr = upc_inc;
            SEQ_JMP:  uaddr = addr;
            SEQ_DISP: uaddr = {DISP_BASE, opcode};
            SEQ_BR:   uaddr = cond_true ? addr : upc_inc;
            default:  uaddr = upc_inc;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds upc, the control word register and the
// instruction register, and fetches the next microword from the control store.
module micro_sequencer
    import cisc_pkg::*;
#(
    parameter int                 UADDR_W   = 6,
    parameter logic [UADDR_W-5:0] DISP_BASE = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CWR_W-1:0]   rom_data,
    output logic [UADDR_W-1:0] uaddr,
    input  logic [INS_W-1:0]   ins_in,
    input  logic               ins_valid,
    output logic               ins_ready,
    input  logic               z_flag,
    input  logic               c_flag,
    input  logic               hold,
    output logic [CWR_W-1:0]   cwr,
    output logic [INS_W-1:0]   ir
);

    logic [UADDR_W-1:0] upc;
    seq_op_e            seq_op;
    cond_e              cond;
    logic               load_ir;
    logic               stall;
    logic               advance;
    logic               load_fire;
    logic [3:0]         opcode;

    assign seq_op  = seq_op_e'(cwr[SEQ_MSB:SEQ_LSB]);
    assign cond    = cond_e'(cwr[COND_MSB:COND_LSB]);
    assign load_ir = cwr[LDIR_BIT];

    // Fetch handshake: ins_ready is high while the current microword asks for
    // an instruction; the transfer happens on the clock edge where
    // ins_ready & ins_valid & ~hold. Until then the sequencer freezes.
    assign ins_ready = load_ir;
    assign stall     = load_ir & ~ins_valid;
    assign advance   = ~hold & ~stall;
    assign load_fire = load_ir & advance;

    // Dispatch sees the incoming opcode on the very cycle it is accepted.
    assign opcode = load_fire ? ins_in[OPC_MSB:OPC_LSB] : ir[OPC_MSB:OPC_LSB];

    upc_next_logic #(
        .UADDR_W   (UADDR_W),
        .DISP_BASE (DISP_BASE)
    ) u_upc_next (
        .upc    (upc),
        .seq_op (seq_op),
        .cond   (cond),
        .addr   (cwr[UADDR_W-1:0]),
        .opcode (opcode),
        .z_flag (z_flag),
        .c_flag (c_flag),
        .uaddr  (uaddr)
    );

    // upc resets to all-ones so the first fetched address wraps to word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            upc <= '1;
            cwr <= '0;
            ir  <= '0;
        end else if (advance) begin
            upc <= uaddr;
            cwr <= rom_data;
            if (load_ir) begin
                ir <= ins_in;
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a behavioural control-store ROM.
module tb_micro_sequencer;
    import cisc_pkg::*;

    logic        clk;
    logic        rst;
    logic [33:0] rom_data;
    logic [5:0]  uaddr;
    logic [15:0] ins_in;
    logic        ins_valid;
    logic        ins_ready;
    logic        z_flag;
    logic        c_flag;
    logic        hold;
    logic [33:0] cwr;
    logic [15:0] ir;

    logic [33:0] rom [64];
    logic [5:0]  exp_q [$];
    logic [5:0]  exp_u;
    int          checks;
    int          errors;

    assign rom_data = rom[uaddr];

    micro_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .rom_data  (rom_data),
        .uaddr     (uaddr),
        .ins_in    (ins_in),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .z_flag    (z_flag),
        .c_flag    (c_flag),
        .hold      (hold),
        .cwr       (cwr),
        .ir        (ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] mw(input logic [1:0] seq, input int tag, input logic ld,
                                       input logic [1:0] cnd, input logic [5:0] a);
        return {seq, 23'(tag), ld, cnd, a};
    endfunction

    task automatic init_rom();
        for (int k = 0; k < 64; k++) rom[k] = mw(SEQ_INC, k * 97 + 3, 1'b0, C_ALW, 6'(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ins_in = '0; ins_valid = 1'b0;
        z_flag = 1'b0; c_flag = 1'b0; hold = 1'b0;
        init_rom();

        // Reset and increment walk with wrap
        step();
        chk("rst_cwr", cwr, 34'd0);
        chk("rst_ir", {18'd0, ir}, 34'd0);
        step();
        chk("rst_cwr2", cwr, 34'd0);
        chk("rst_uaddr", {28'd0, uaddr}, 34'd0);
        rst = 1'b0;
        for (int k = 0; k < 64; k++) exp_q.push_back(6'((k + 1) % 64));
        for (int k = 0; k < 64; k++) begin
            step();
            exp_u = exp_q.pop_front();
            chk("inc_cwr", cwr, rom[k]);
            chk("inc_uaddr", {28'd0, uaddr}, {28'd0, exp_u});
        end
        step();
        chk("wrap_cwr", cwr, rom[0]);
        chk("wrap_uaddr", {28'd0, uaddr}, 34'd1);

        // Jump
        init_rom();
        rom[3] = mw(SEQ_JMP, 777, 1'b0, C_ALW, 6'd40);
        do_reset(1);
        repeat (4) step();
        chk("jmp_cwr3", cwr, rom[3]);
        chk("jmp_uaddr", {28'd0, uaddr}, 34'd40);
        step();
        chk("jmp_cwr40", cwr, rom[40]);
        chk("jmp_uaddr41", {28'd0, uaddr}, 34'd41);

        // Conditional branch chain: 5 (Z), 6 (NZ), 7 (C), 21 (always, self-loop)
        init_rom();
        rom[5]  = mw(SEQ_BR, 501, 1'b0, C_Z,   6'd20);
        rom[6]  = mw(SEQ_BR, 601, 1'b0, C_NZ,  6'd20);
        rom[7]  = mw(SEQ_BR, 701, 1'b0, C_C,   6'd20);
        rom[21] = mw(SEQ_BR, 2101, 1'b0, C_ALW, 6'd21);
        do_reset(1);
        repeat (6) step();
        chk("br_cwr5", cwr, rom[5]);
        z_flag = 1'b1; settle();
        chk("br_z1", {28'd0, uaddr}, 34'd20);
        z_flag = 1'b0; settle();
        chk("br_z0", {28'd0, uaddr}, 34'd6);
        step();
        chk("br_cwr6", cwr, rom[6]);
        chk("br_nz_z0", {28'd0, uaddr}, 34'd20);
        z_flag = 1'b1; settle();
        chk("br_nz_z1", {28'd0, uaddr}, 34'd7);
        step();
        chk("br_cwr7", cwr, rom[7]);
        c_flag = 1'b1; settle();
        chk("br_c1", {28'd0, uaddr}, 34'd20);
        c_flag = 1'b0; settle();
        chk("br_c0", {28'd0, uaddr}, 34'd8);
        c_flag = 1'b1; settle();
        step();
        chk("br_cwr20", cwr, rom[20]);
        z_flag = 1'b0; c_flag = 1'b0;
        step();
        chk("loop_cwr21", cwr, rom[21]);
        chk("loop_uaddr", {28'd0, uaddr}, 34'd21);
        z_flag = 1'b1; c_flag = 1'b1;
        step();
        chk("loop_cwr21b", cwr, rom[21]);
        chk("loop_uaddr_b", {28'd0, uaddr}, 34'd21);
        z_flag = 1'b0; c_flag = 1'b0;

        // Dispatch with same-cycle fetch
        init_rom();
        rom[0] = mw(SEQ_DISP, 4242, 1'b1, C_ALW, 6'd0);
        do_reset(1);
        ins_in = 16'h1A2B; ins_valid = 1'b1;
        step();
        chk("disp_cwr0", cwr, rom[0]);
        chk("disp_ready", {33'd0, ins_ready}, 34'd1);
        chk("disp_uaddr", {28'd0, uaddr}, 34'h11);
        step();
        chk("disp_ir", {18'd0, ir}, 34'h1A2B);
        chk("disp_cwr17", cwr, rom[17]);
        chk("disp_ready0", {33'd0, ins_ready}, 34'd0);
        chk("disp_uaddr18", {28'd0, uaddr}, 34'd18);

        // Fetch stall for 3 cycles, then accept
        ins_valid = 1'b0; ins_in = 16'hC3D4;
        do_reset(1);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("stall_cwr", cwr, rom[0]);
            chk("stall_ir", {18'd0, ir}, 34'd0);
            chk("stall_ready", {33'd0, ins_ready}, 34'd1);
            step();
        end
        ins_valid = 1'b1; settle();
        chk("stall_uaddr", {28'd0, uaddr}, 34'h1C);
        step();
        chk("stall_ir_ld", {18'd0, ir}, 34'hC3D4);
        chk("stall_cwr28", cwr, rom[28]);
        chk("stall_uaddr29", {28'd0, uaddr}, 34'd29);

        // Hold overrides a valid instruction
        ins_valid = 1'b0;
        do_reset(1);
        step();
        hold = 1'b1; ins_valid = 1'b1; ins_in = 16'h5E6F;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_cwr", cwr, rom[0]);
            chk("hold_ir", {18'd0, ir}, 34'd0);
            chk("hold_ready", {33'd0, ins_ready}, 34'd1);
        end
        hold = 1'b0; settle();
        chk("hold_uaddr", {28'd0, uaddr}, 34'd21);
        step();
        chk("hold_ir_ld", {18'd0, ir}, 34'h5E6F);
        chk("hold_cwr21", cwr, rom[21]);
        ins_valid = 1'b0;
        hold = 1'b1;
        repeat (2) step();
        chk("hold_inc_cwr", cwr, rom[21]);
        hold = 1'b0; settle();
        chk("hold_inc_uaddr", {28'd0, uaddr}, 34'd22);

        // Reset while stalled on a fetch
        rom[22] = mw(SEQ_DISP, 2222, 1'b1, C_ALW, 6'd0);
        step();
        chk("mid_cwr22", cwr, rom[22]);
        chk("mid_ready", {33'd0, ins_ready}, 34'd1);
        step();
        chk("mid_stall_cwr", cwr, rom[22]);
        rst = 1'b1;
        step();
        chk("mid_rst_cwr", cwr, 34'd0);
        chk("mid_rst_ir", {18'd0, ir}, 34'd0);
        chk("mid_rst_uaddr", {28'd0, uaddr}, 34'd0);
        rst = 1'b0;
        step();
        chk("mid_post_cwr", cwr, rom[0]);
        chk("mid_post_ready", {33'd0, ins_ready}, 34'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
